mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
- Execute-stage sequencer for RV32M MUL/MULH/MULHSU/MULHU. Sits between the execute stage and the Booth multiplier.
- Latches operands, maps funct3 to operand signedness, and pulses the multiplier start.
- Stalls the pipeline until the multiplier is done, then returns the low or high 32 bits.
- Keeps a one-entry result cache so a MULH/MUL pair on the same operands costs a single multiply.

Parameters:
CACHE_EN, 1, 1 = enable the one-entry result cache; 0 = every request issues a multiply.

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
req_valid  in  1  execute stage presents an M-class op; held stable with operands while stall=1
req_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
req_rs1  in  32  operand a
req_rs2  in  32  operand b
flush  in  1  kill the current instruction (branch/trap)
stall  out  1  hold the pipeline
resp_valid  out  1  one-cycle result strobe
resp_data  out  32  result
mult_en  out  1  multiplier start
mult_a  out  32  multiplicand
mult_b  out  32  multiplier
mult_is_signed_a  out  1  sign-extend a
mult_is_signed_b  out  1  sign-extend b
mult_out  in  64  product
mult_ready  in  1  multiplier idle (low while busy)

Behaviour:
- Reset (nrst=0 at clk edge) forces:
  - state=IDLE; cache_valid=0.
  - stall=0, resp_valid=0, resp_data=0, mult_en=0.
  - mult_a=0, mult_b=0, mult_is_signed_a=0, mult_is_signed_b=0.
  - Reset overrides any in-flight operation.
- req_funct3[2]=1 (divide ops) is not this block's: ignored, no stall.
- Signedness mapping (sa, sb):
  - 000 → (1,1)
  - 001 → (1,1)
  - 010 → (1,0)
  - 011 → (0,0)
- Cache hit requires all of: CACHE_EN, cache_valid, rs1==tag_a, rs2==tag_b, and either funct3=000 (low half is signedness-independent) or (sa,sb)==tag signedness.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
  - IDLE:
    - req_valid & !flush & hit → DONE.
    - req_valid & !flush & miss → latch rs1, rs2, sa, sb and funct3 into the mult_* registers; go to ISSUE.
  - ISSUE:
    - mult_en=1 for exactly this cycle; go to WAIT.
    - flush in ISSUE suppresses mult_en and goes to IDLE.
  - WAIT:
    - mult_ready is ignored on the first WAIT cycle, because the multiplier still reports ready on its start cycle.
    - From the second WAIT cycle, mult_ready=1 → capture mult_out into the result register, load tags and set cache_valid; go to DONE.
    - flush in WAIT → DRAIN.
  - DONE:
    - resp_valid=1 and resp_data = funct3==000 ? result[31:0] : result[63:32]; go to IDLE.
    - flush in DONE forces resp_valid=0; go to IDLE. The cache update is retained.
  - DRAIN:
    - Wait for mult_ready (from the second cycle after entry), then go to IDLE with cache_valid=0.
    - mult_en=0 throughout.
- stall = (IDLE & accepted request) | ISSUE | WAIT | (DRAIN & req_valid). stall=0 in DONE, and the pipeline advances that cycle.
- Latency from accept to resp_valid:
  - hit: 1 cycle.
  - miss: 2 + multiplier busy cycles + 1.
- resp_data holds its value after DONE until the next DONE.
- mult_a, mult_b and the signedness outputs stay constant from ISSUE until the next accepted miss.

Test Plan:
- MUL rs1=0x00000007, rs2=0x00000006 → resp_data=0x0000002A, one resp_valid pulse, stall high from accept until DONE, mult_en high exactly 1 cycle.
- MULH/MULHSU/MULHU back-to-back with rs1=rs2=0xFFFFFFFF → 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE. Each signedness change misses and issues a new multiply.
- MULH 0x80000000×0x80000000 → 0x40000000, then MUL on the same operands → 0x00000000 with a hit: 1-cycle latency and no mult_en.
- Flush during WAIT → no resp_valid, DRAIN until mult_ready, cache_valid=0. The following MUL 3×5 → 15 with a fresh multiply.
- Flush in ISSUE → mult_en never asserted, back to IDLE. Flush in DONE → resp_valid stays 0.
- nrst=0 mid-WAIT → all outputs zero next cycle. CACHE_EN=0 → a repeated identical MUL issues mult_en again.

Source files
------------

// File: rtl/mul_ctrl.sv
// Execute-stage sequencer for RV32M MUL/MULH/MULHSU/MULHU driving an external multiplier.
// Latency: cache hit 1 cycle after accept; miss = issue + wait-for-ready + 1 result cycle.
// Backpressure: stall holds the pipeline from accept until the DONE cycle; flush aborts.
module mul_ctrl #(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        flush,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        mult_en,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic        mult_is_signed_a,
    output logic        mult_is_signed_b,
    input  logic [63:0] mult_out,
    input  logic        mult_ready
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

    state_t      state_q, state_d;
    logic        first_q;        // first cycle in WAIT/DRAIN: multiplier ready is stale
    logic [2:0]  f3_q;           // funct3 of the instruction being answered
    logic [63:0] result_q;
    logic [31:0] tag_a_q, tag_b_q;
    logic        tag_sa_q, tag_sb_q;
    logic        cache_valid_q;
    logic [31:0] resp_q;

    logic        req_sa, req_sb, accept, hit, capture, drain_done;
    logic [31:0] result_sel;

    // MUL/MULH are signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
    assign req_sa = (req_funct3[1:0] != 2'b11);
    assign req_sb = ~req_funct3[1];
    // funct3[2]=1 are divide ops, which belong to another unit.
    assign accept = req_valid & ~flush & ~req_funct3[2];
    // The low product half does not depend on signedness, so MUL matches any cached signedness.
    assign hit = CACHE_EN && cache_valid_q &&
                 (req_rs1 == tag_a_q) && (req_rs2 == tag_b_q) &&
                 ((req_funct3[1:0] == 2'b00) ||
                  ((req_sa == tag_sa_q) && (req_sb == tag_sb_q)));
    assign result_sel = (f3_q[1:0] == 2'b00) ? result_q[31:0] : result_q[63:32];
    assign resp_data  = resp_valid ? result_sel : resp_q;

    // Next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        resp_valid = 1'b0;
        mult_en    = 1'b0;
        capture    = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = hit ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    mult_en = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = DRAIN;
                end else if (!first_q && mult_ready) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid = ~flush;
                state_d    = IDLE;
            end
            DRAIN: begin
                stall = req_valid;
                if (!first_q && mult_ready) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, result and cache registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q          <= IDLE;
            first_q          <= 1'b0;
            f3_q             <= 3'b000;
            result_q         <= '0;
            tag_a_q          <= '0;
            tag_b_q          <= '0;
            tag_sa_q         <= 1'b0;
            tag_sb_q         <= 1'b0;
            cache_valid_q    <= 1'b0;
            resp_q           <= '0;
            mult_a           <= '0;
            mult_b           <= '0;
            mult_is_signed_a <= 1'b0;
            mult_is_signed_b <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
            if (state_q == IDLE && accept) begin
                f3_q <= req_funct3;
                if (!hit) begin
                    mult_a           <= req_rs1;
                    mult_b           <= req_rs2;
                    mult_is_signed_a <= req_sa;
                    mult_is_signed_b <= req_sb;
                end
            end
            if (capture) begin
                result_q      <= mult_out;
                tag_a_q       <= mult_a;
                tag_b_q       <= mult_b;
                tag_sa_q      <= mult_is_signed_a;
                tag_sb_q      <= mult_is_signed_b;
                cache_valid_q <= 1'b1;
            end
            if (drain_done) begin
                cache_valid_q <= 1'b0;
            end
            if (resp_valid) begin
                resp_q <= result_sel;
            end
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Bench for mul_ctrl: instance 0 with the result cache, instance 1 without.
// Each instance talks to its own behavioural multiplier with a fixed busy time.
// Vectors carry hand-computed results; multi-cycle flush/reset cases are hand sequences.
module tb_mul_ctrl;

    localparam int BUSY     = 3;
    localparam int MISS_LAT = BUSY + 4;  // accept, issue, stale-ready wait, BUSY busy, ready wait

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2;
    logic        flush;

    logic        stall_o[2], resp_o[2], men_o[2], msa[2], msb[2], mrdy[2];
    logic [31:0] rd_o[2], ma[2], mb[2];
    logic [63:0] prod[2];
    int          cnt[2];

    logic        sel;
    logic        s_stall, s_resp, s_men;
    logic [31:0] s_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_ctrl #(.CACHE_EN(1'b1)) dut0 (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
        .stall(stall_o[0]), .resp_valid(resp_o[0]), .resp_data(rd_o[0]),
        .mult_en(men_o[0]), .mult_a(ma[0]), .mult_b(mb[0]),
        .mult_is_signed_a(msa[0]), .mult_is_signed_b(msb[0]),
        .mult_out(prod[0]), .mult_ready(mrdy[0])
    );

    mul_ctrl #(.CACHE_EN(1'b0)) dut1 (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
        .stall(stall_o[1]), .resp_valid(resp_o[1]), .resp_data(rd_o[1]),
        .mult_en(men_o[1]), .mult_a(ma[1]), .mult_b(mb[1]),
        .mult_is_signed_a(msa[1]), .mult_is_signed_b(msb[1]),
        .mult_out(prod[1]), .mult_ready(mrdy[1])
    );

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
        logic [63:0] ea, eb;
        ea = {{32{sa & a[31]}}, a};
        eb = {{32{sb & b[31]}}, b};
        return ea * eb;
    endfunction

    // Multiplier model: ready stays high on the cycle after start, then drops for BUSY cycles.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!nrst) begin
                cnt[i] <= 0;
            end else if (men_o[i]) begin
                cnt[i]  <= BUSY + 1;
                prod[i] <= mul64(ma[i], mb[i], msa[i], msb[i]);
            end else if (cnt[i] != 0) begin
                cnt[i] <= cnt[i] - 1;
            end
        end
    end
    assign mrdy[0] = (cnt[0] == 0) || (cnt[0] == BUSY + 1);
    assign mrdy[1] = (cnt[1] == 0) || (cnt[1] == BUSY + 1);

    assign s_stall = stall_o[sel];
    assign s_resp  = resp_o[sel];
    assign s_men   = men_o[sel];
    assign s_data  = rd_o[sel];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Walk cycles from the current negedge until resp_valid, counting mult_en and stall errors.
    task automatic wait_resp(output int lat, output logic [31:0] d, output int men,
                             output int sbad, output bit got);
        lat = 0; d = '0; men = 0; sbad = 0; got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (s_men) men++;
            if (s_resp) begin
                got = 1'b1;
                lat = c;
                d   = s_data;
                if (s_stall) sbad++;
                return;
            end
            if (!s_stall) sbad++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit hit);
        int lat, men, sbad;
        logic [31:0] d;
        bit got;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b;
        wait_resp(lat, d, men, sbad, got);
        req_valid = 1'b0;
        chk({nm, "_got"},   64'(got), 64'd1);
        chk({nm, "_data"},  64'(d), 64'(exp));
        chk({nm, "_lat"},   64'(lat), hit ? 64'd1 : 64'(MISS_LAT));
        chk({nm, "_men"},   64'(men), hit ? 64'd0 : 64'd1);
        chk({nm, "_stall"}, 64'(sbad), 64'd0);
        @(negedge clk); #1;
        chk({nm, "_pulse"}, 64'(s_resp), 64'd0);
        chk({nm, "_hold"},  64'(s_data), 64'(exp));
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          hit;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int lat, men, sbad, cnt_m, cnt_r, cnt_s;
        logic [31:0] d;
        bit got;

        //             f3      rs1           rs2           result        hit
        tbl[0]  = '{3'b000, 32'h00000007, 32'h00000006, 32'h0000002A, 1'b0};
        tbl[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        tbl[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        tbl[4]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1};
        tbl[5]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        tbl[6]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
        tbl[7]  = '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
        tbl[8]  = '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1};
        tbl[9]  = '{3'b010, 32'h80000000, 32'h00000003, 32'hFFFFFFFE, 1'b0};
        tbl[10] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0};
        tbl[11] = '{3'b001, 32'h12345678, 32'h00000010, 32'h00000001, 1'b1};

        sel = 1'b0;
        nrst = 1'b0; req_valid = 1'b0; req_funct3 = 3'b000;
        req_rs1 = '0; req_rs2 = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl", {59'd0, s_stall, s_resp, s_men, msa[0], msb[0]}, 64'd0);
        chk("rst_data", 64'(s_data), 64'd0);
        chk("rst_ab",   {ma[0], mb[0]}, 64'd0);
        nrst = 1'b1;

        // Divide-class funct3 is ignored: no stall, no multiply.
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'd9; req_rs2 = 32'd3;
        cnt_m = 0; cnt_s = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (s_men) cnt_m++;
            if (s_stall) cnt_s++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("div_stall", 64'(cnt_s), 64'd0);
        chk("div_men",   64'(cnt_m), 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("v%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].hit);
        end

        // Flush in WAIT while the next op is already presented: drain, then a fresh multiply.
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b011; req_rs1 = 32'h10; req_rs2 = 32'h10;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (s_men) got = 1'b1;
            @(negedge clk);
        end
        chk("wflush_issue", 64'(got), 64'd1);
        @(negedge clk);
        flush = 1'b1; req_funct3 = 3'b001; req_rs1 = 32'h12345678; req_rs2 = 32'h10;
        #1;
        chk("wflush_resp", 64'(s_resp), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("drain_stall", 64'(s_stall), 64'd1);
        chk("drain_men",   64'(s_men), 64'd0);
        wait_resp(lat, d, men, sbad, got);
        req_valid = 1'b0;
        chk("wflush_got",   64'(got), 64'd1);
        chk("wflush_data",  64'(d), 64'h1);
        chk("wflush_men",   64'(men), 64'd1);
        chk("wflush_stall", 64'(sbad), 64'd0);
        run_op("mul3x5", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0);

        // Flush in ISSUE: no mult_en, back to IDLE with the cache intact.
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd9; req_rs2 = 32'd9;
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b0;
        #1;
        chk("iflush_men", 64'(s_men), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        cnt_m = 0; cnt_r = 0; cnt_s = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (s_men) cnt_m++;
            if (s_resp) cnt_r++;
            if (s_stall) cnt_s++;
            @(negedge clk);
        end
        chk("iflush_men_after", 64'(cnt_m), 64'd0);
        chk("iflush_resp",      64'(cnt_r), 64'd0);
        chk("iflush_idle",      64'(cnt_s), 64'd0);
        run_op("iflush_hit", 3'b000, 32'd3, 32'd5, 32'd15, 1'b1);

        // Flush in DONE: strobe suppressed, cache update kept.
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b011; req_rs1 = 32'd3; req_rs2 = 32'd5;
        wait_resp(lat, d, men, sbad, got);
        chk("dflush_reach", 64'(got), 64'd1);
        flush = 1'b1; req_valid = 1'b0;
        #1;
        chk("dflush_resp", 64'(s_resp), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("dflush_resp_after", 64'(s_resp), 64'd0);
        run_op("dflush_hit", 3'b011, 32'd3, 32'd5, 32'd0, 1'b1);
        run_op("pre_rst", 3'b000, 32'd3, 32'd5, 32'd15, 1'b1);

        // Reset in the middle of WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'h55; req_rs2 = 32'h2;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (s_men) got = 1'b1;
            @(negedge clk);
        end
        chk("rwait_issue", 64'(got), 64'd1);
        @(negedge clk);
        nrst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rwait_ctrl", {59'd0, s_stall, s_resp, s_men, msa[0], msb[0]}, 64'd0);
        chk("rwait_data", 64'(s_data), 64'd0);
        chk("rwait_ab",   {ma[0], mb[0]}, 64'd0);
        nrst = 1'b1;
        run_op("post_rst", 3'b000, 32'd3, 32'd5, 32'd15, 1'b0);

        // Without the cache, an identical repeat multiplies again.
        sel = 1'b1;
        run_op("nc_a", 3'b000, 32'd7, 32'd6, 32'h2A, 1'b0);
        run_op("nc_b", 3'b000, 32'd7, 32'd6, 32'h2A, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
